// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered, handshaked 9-bit control decoder with branch flag and load-use interlock
// Optional feature macro: ILLEGAL_CNT_EN (adds a saturating illegal_cnt port)
module ctrl_decode_stage #(
  parameter int OPW  = 9,
  parameter int RAW  = 4,
  parameter int AOPW = 5,
  parameter int FLW  = 3,
  parameter int CNTW = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            in_valid,
  input  logic [OPW-1:0]  instr,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            Branch,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            Immed,
  output logic            Illegal,
  output logic [RAW-1:0]  ReadAddr1,
  output logic [RAW-1:0]  ReadAddr2,
  output logic [RAW-1:0]  WriteAddr,
  output logic [AOPW-1:0] ALUOp,
`ifdef ILLEGAL_CNT_EN
  output logic [CNTW-1:0] illegal_cnt,
`endif
  output logic [FLW-1:0]  BrFlag
);

  localparam logic [RAW-1:0]  RA1_DEF  = RAW'(4'b1000);
  localparam logic [RAW-1:0]  RA2_DEF  = RAW'(4'b1001);
  localparam logic [RAW-1:0]  WA_DEF   = RAW'(4'b0000);
  localparam logic [RAW-1:0]  WA_LINK  = RAW'(4'b1111);
  localparam logic [AOPW-1:0] AOP_DEF  = AOPW'(5'b11111);
  localparam logic [AOPW-1:0] AOP_ADD  = AOPW'(5'b00000);
  localparam logic [FLW-1:0]  FLAG_RST = FLW'(3'b100);

  logic [8:0] op;
  logic       unused_instr;

  assign op           = instr[8:0];
  assign unused_instr = ^instr;

  logic            d_branch, d_memtoreg, d_memwrite, d_alusrc, d_regwrite, d_immed, d_illegal;
  logic            d_mov, d_lb, d_sbf;
  logic [RAW-1:0]  d_ra1, d_ra2, d_wa;
  logic [AOPW-1:0] d_aluop;

  always_comb begin
    d_branch   = 1'b0;
    d_memtoreg = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_regwrite = 1'b0;
    d_immed    = 1'b0;
    d_illegal  = 1'b0;
    d_mov      = 1'b0;
    d_lb       = 1'b0;
    d_sbf      = 1'b0;
    d_ra1      = RA1_DEF;
    d_ra2      = RA2_DEF;
    d_wa       = WA_DEF;
    d_aluop    = AOP_DEF;
    if (!op[8]) begin
      d_mov      = 1'b1;
      d_ra1      = RAW'(op[3:0]);
      d_ra2      = RAW'(op[3:0]);
      d_wa       = RAW'(op[7:4]);
      d_aluop    = AOP_ADD;
      d_regwrite = 1'b1;
    end else if (op[7:6] == 2'b00) begin
      d_branch = 1'b1;
      d_immed  = 1'b1;
    end else if (op[7:6] == 2'b01) begin
      d_immed    = 1'b1;
      d_regwrite = 1'b1;
      d_wa       = WA_LINK;
    end else if (op[7:6] == 2'b10) begin
      d_wa       = RAW'({2'b10, op[4:3]});
      d_alusrc   = (op[2:0] != 3'b000);
      d_aluop    = op[5] ? AOPW'(5'b10001) : AOPW'(5'b10000);
      d_regwrite = 1'b1;
    end else if (!op[5]) begin
      if (op[4:3] == 2'b11) begin
        // sbf: only 000..100 are legal flag values
        if (op[2:0] > 3'b100) d_illegal = 1'b1;
        else                  d_sbf     = 1'b1;
      end else begin
        d_wa       = RAW'({2'b10, op[1:0]});
        d_regwrite = 1'b1;
        case (op[4:2])
          3'b000:  d_aluop = AOPW'(5'b00100);
          3'b001:  d_aluop = AOPW'(5'b00101);
          3'b010:  d_aluop = AOPW'(5'b00000);
          3'b011:  d_aluop = AOPW'(5'b00001);
          3'b100:  d_aluop = AOPW'(5'b00010);
          3'b101:  d_aluop = AOPW'(5'b00011);
          default: begin
            d_aluop    = AOP_DEF;
            d_regwrite = 1'b0;
            d_illegal  = 1'b1;
          end
        endcase
      end
    end else if (!op[4]) begin
      d_ra1   = RAW'({1'b0, op[2:0]});
      d_ra2   = RAW'({1'b0, op[2:0]});
      d_aluop = AOP_ADD;
      if (!op[3]) begin
        d_lb       = 1'b1;
        d_wa       = WA_LINK;
        d_regwrite = 1'b1;
        d_memtoreg = 1'b1;
      end else begin
        d_memwrite = 1'b1;
      end
    end else begin
      d_illegal = 1'b1;
    end
  end

  logic           lb_q;
  logic [FLW-1:0] flag_q;
  logic           adv, hazard, xfer_in;

  assign adv      = ~out_valid | out_ready;
  assign hazard   = in_valid & lb_q & d_mov & (op[3:0] == 4'b1111);
  assign in_ready = adv & ~hazard;
  assign xfer_in  = in_valid & in_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      lb_q      <= 1'b0;
      flag_q    <= FLAG_RST;
      Branch    <= 1'b0;
      MemtoReg  <= 1'b0;
      MemWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      RegWrite  <= 1'b0;
      Immed     <= 1'b0;
      Illegal   <= 1'b0;
      ReadAddr1 <= RA1_DEF;
      ReadAddr2 <= RA2_DEF;
      WriteAddr <= WA_DEF;
      ALUOp     <= AOP_DEF;
      BrFlag    <= FLAG_RST;
    end else if (adv) begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        lb_q      <= d_lb;
        Branch    <= d_branch;
        MemtoReg  <= d_memtoreg;
        MemWrite  <= d_memwrite;
        ALUSrc    <= d_alusrc;
        RegWrite  <= d_regwrite;
        Immed     <= d_immed;
        Illegal   <= d_illegal;
        ReadAddr1 <= d_ra1;
        ReadAddr2 <= d_ra2;
        WriteAddr <= d_wa;
        ALUOp     <= d_aluop;
        // The flag updates on the same edge, so a b accepted next cycle sees the new value
        BrFlag    <= flag_q;
        if (d_sbf) flag_q <= FLW'(op[2:0]);
      end else begin
        out_valid <= 1'b0;
        lb_q      <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      illegal_cnt <= '0;
    end else if (xfer_in && d_illegal && (illegal_cnt != {CNTW{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cntw = CNTW;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - directed self-checking bench for ctrl_decode_stage
module tb_ctrl_decode_stage;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic [8:0] instr;
  logic       in_ready, out_valid, out_ready;
  logic       Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Immed, Illegal;
  logic [3:0] ReadAddr1, ReadAddr2, WriteAddr;
  logic [4:0] ALUOp;
  logic [2:0] BrFlag;
`ifdef ILLEGAL_CNT_EN
  logic [1:0] illegal_cnt;
`endif

  int errors = 0;
  int checks = 0;

  ctrl_decode_stage #(.OPW(9), .RAW(4), .AOPW(5), .FLW(3), .CNTW(2)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .Branch(Branch), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Immed(Immed),
    .Illegal(Illegal), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .WriteAddr(WriteAddr),
    .ALUOp(ALUOp),
`ifdef ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt),
`endif
    .BrFlag(BrFlag)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] i);
    in_valid = v;
    instr    = i;
    #1;
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_out_valid", 9'(out_valid), 9'd0);
    chk("rst_brflag", 9'(BrFlag), 9'b100);
    chk("rst_ra1", 9'(ReadAddr1), 9'b1000);
    chk("rst_ra2", 9'(ReadAddr2), 9'b1001);
    chk("rst_wa", 9'(WriteAddr), 9'b0000);
    chk("rst_aluop", 9'(ALUOp), 9'b11111);
    chk("rst_ctrl", 9'({Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Immed, Illegal}), 9'd0);
    chk("rst_in_ready", 9'(in_ready), 9'd1);

    // mov r3 <- r5
    drive(1'b1, 9'b0_0011_0101); tick();
    chk("mov_valid", 9'(out_valid), 9'd1);
    chk("mov_wa", 9'(WriteAddr), 9'b0011);
    chk("mov_ra", 9'({ReadAddr1, ReadAddr2}), 9'b0101_0101);
    chk("mov_aluop", 9'(ALUOp), 9'b00000);
    chk("mov_regwrite", 9'(RegWrite), 9'd1);

    // sbf 010, then b back-to-back: b sees forwarded flag
    drive(1'b1, 9'b1_1101_1010); tick();
    chk("sbf_ctrl", 9'({Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Immed, Illegal}), 9'd0);
    drive(1'b1, 9'b1_0000_0000); tick();
    chk("b_branch_immed", 9'({Branch, Immed}), 9'b11);
    chk("b_brflag", 9'(BrFlag), 9'b010);
    drive(1'b1, 9'b1_1101_1110); tick();
    chk("sbf_bad_illegal", 9'(Illegal), 9'd1);
    drive(1'b1, 9'b1_0000_0000); tick();
    chk("b_flag_kept", 9'(BrFlag), 9'b010);

    // lb then dependent mov: one bubble
    drive(1'b1, 9'b1_1110_0011); tick();
    chk("lb_fields", 9'({MemtoReg, RegWrite, WriteAddr}), 9'b11_1111);
    chk("lb_ra1", 9'(ReadAddr1), 9'b0011);
    drive(1'b1, 9'b0_0001_1111);
    chk("hz_in_ready", 9'(in_ready), 9'd0);
    tick();
    chk("hz_bubble", 9'(out_valid), 9'd0);
    chk("hz_in_ready_after", 9'(in_ready), 9'd1);
    tick();
    chk("hz_mov_out", 9'({out_valid, WriteAddr, ReadAddr1}), 9'b1_0001_1111);

    // lb then independent mov: no bubble
    drive(1'b1, 9'b1_1110_0011); tick();
    drive(1'b1, 9'b0_0001_0010);
    chk("nohz_in_ready", 9'(in_ready), 9'd1);
    tick();
    chk("nohz_mov_out", 9'({out_valid, WriteAddr, ReadAddr1}), 9'b1_0001_0010);

    // add held for 3 cycles under back-pressure
    drive(1'b1, 9'b1_1100_0001); tick();
    chk("add_out", 9'({ALUOp, WriteAddr}), 9'b00100_1001);
    out_ready = 1'b0;
    drive(1'b1, 9'b1_0100_0000);
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 9'(in_ready), 9'd0);
      tick();
      chk("stall_held", 9'({out_valid, ALUOp, WriteAddr[2:0]}), 9'b1_00100_001);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 9'(in_ready), 9'd1);
    tick();
    chk("li_out", 9'({out_valid, Immed, RegWrite, WriteAddr}), 9'b1_1_1_1111);
    chk("li_aluop", 9'(ALUOp), 9'b11111);

    // shift right with nonzero shamt, then sb
    drive(1'b1, 9'b1_1010_1101); tick();
    chk("shift_out", 9'({ALUSrc, RegWrite, ALUOp[0], WriteAddr}), 9'b1_1_1_1001);
    drive(1'b1, 9'b1_1110_1101); tick();
    chk("sb_out", 9'({MemWrite, RegWrite, ReadAddr1}), 9'b1_0_0101);

    // 1_1101_1000 decodes as sbf with flag 000 (instr[4:3]=11)
    drive(1'b1, 9'b1_1101_1000); tick();
    chk("sbf000_ctrl", 9'({RegWrite, Illegal, ALUOp}), 9'b0_0_11111);
    drive(1'b1, 9'b1_0000_0000); tick();
    chk("b_flag000", 9'(BrFlag), 9'b000);
    drive(1'b1, 9'b1_1111_0000); tick();
    chk("ill_out", 9'({Illegal, RegWrite, ALUOp}), 9'b1_0_11111);
    drive(1'b1, 9'b1_1111_0101); tick();
    drive(1'b1, 9'b1_1101_1111); tick();
    drive(1'b1, 9'b1_1111_1111); tick();
`ifdef ILLEGAL_CNT_EN
    chk("illegal_cnt_sat", 9'(illegal_cnt), 9'd3);
`endif

    // reset while stalled discards held word
    drive(1'b1, 9'b1_1100_0001); tick();
    out_ready = 1'b0;
    drive(1'b0, 9'd0); tick();
    chk("pre_rst_held", 9'(out_valid), 9'd1);
    Reset = 1'b1; tick();
    Reset = 1'b0;
    chk("midrst_valid", 9'(out_valid), 9'd0);
    chk("midrst_brflag", 9'(BrFlag), 9'b100);
    chk("midrst_fields", 9'({WriteAddr, ALUOp}), 9'b0000_11111);
    chk("midrst_ra", 9'({ReadAddr1, ReadAddr2}), 9'b1000_1001);
    chk("midrst_ctrl", 9'({Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Immed, Illegal}), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
